// File: rtl/hls_stream_pkg.sv
// Shared types and helpers for the ap_-controlled streaming layers.
package hls_stream_pkg;

  localparam int unsigned SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ap_state_e;

  // Signed maximum; a tie returns the first argument (the earlier sample).
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/max_window.sv
// Running signed maximum over a window of POOL samples.
module max_window
  import hls_stream_pkg::*;
#(
  parameter int unsigned POOL = 4
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_clr,
  input  logic    i_en,
  input  sample_t i_din,
  output logic    o_last_c,
  output sample_t o_max_c
);

  localparam int unsigned POS_W = (POOL > 1) ? $clog2(POOL) : 1;

  logic [POS_W-1:0] r_win_pos;
  sample_t          r_acc;
  logic             w_first;
  logic             w_last;

  assign w_first  = (r_win_pos == '0);
  assign w_last   = (r_win_pos == POS_W'(POOL - 1));
  assign o_last_c = i_en & w_last;
  assign o_max_c  = smax(r_acc, i_din);

  // Window position and accumulator advance on every accepted sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_win_pos <= '0;
      r_acc     <= '0;
    end else if (i_clr) begin
      r_win_pos <= '0;
    end else if (i_en) begin
      r_win_pos <= w_last ? '0 : r_win_pos + POS_W'(1);
      r_acc     <= w_first ? i_din : smax(r_acc, i_din);
    end
  end

endmodule

// File: rtl/max_pooling1d_stream.sv
// Streaming 1-D max pooling: NIN samples in, NIN/POOL window maxima out.
module max_pooling1d_stream
  import hls_stream_pkg::*;
#(
  parameter int unsigned DW   = SAMPLE_W,
  parameter int unsigned NIN  = 97,
  parameter int unsigned POOL = 4
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  input  logic          ap_continue,
  output logic          ap_done,
  output logic          ap_ready,
  output logic          ap_idle,
  input  logic [DW-1:0] layer4_out_V_data_V_dout,
  input  logic          layer4_out_V_data_V_empty_n,
  output logic          layer4_out_V_data_V_read,
  output logic [DW-1:0] layer5_out_V_data_V_din,
  input  logic          layer5_out_V_data_V_full_n,
  output logic          layer5_out_V_data_V_write
);

  localparam int unsigned NOUT  = NIN / POOL;
  localparam int unsigned REM   = NIN % POOL;
  localparam int unsigned IN_W  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int unsigned OUT_W = $clog2(NOUT + 1);

  generate
    if (NIN < POOL || POOL < 2 || DW != SAMPLE_W) begin : g_param_check
      $error("max_pooling1d_stream: need NIN >= POOL, POOL >= 2, DW == SAMPLE_W");
    end
  endgenerate

  ap_state_e        r_state;
  ap_state_e        w_state_nxt;
  logic [IN_W-1:0]  r_in_cnt;
  logic [OUT_W-1:0] r_out_cnt;
  sample_t          r_out_reg;
  logic             r_out_valid;
  logic             r_in_done;
  logic             r_ready;

  logic             w_read;
  logic             w_write;
  logic             w_run_rd;
  logic             w_win_last;
  sample_t          w_max;
  logic             w_frame_start;
  logic             w_last_in;
  logic             w_last_win;
  logic             w_ov_nxt;

  assign w_run_rd      = w_read & (r_state == ST_RUN);
  assign w_frame_start = ap_start & ((r_state == ST_IDLE) |
                                     ((r_state == ST_DONE) & ap_continue));
  assign w_last_in     = w_read & (r_in_cnt == IN_W'(NIN - 1));
  assign w_last_win    = w_win_last & (r_out_cnt == OUT_W'(NOUT - 1));
  assign w_ov_nxt      = w_win_last | (r_out_valid & ~w_write);

  max_window #(.POOL(POOL)) u_win (
    .i_clk    (ap_clk),
    .i_rst_n  (ap_rst_n),
    .i_clr    (w_frame_start),
    .i_en     (w_run_rd),
    .i_din    (sample_t'(layer4_out_V_data_V_dout)),
    .o_last_c (w_win_last),
    .o_max_c  (w_max)
  );

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state; DONE is only entered once input is exhausted and no result is pending.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ap_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last_win && (REM != 0))                  w_state_nxt = ST_FLUSH;
        else if ((r_in_done || w_last_in) && !w_ov_nxt) w_state_nxt = ST_DONE;
      end
      ST_FLUSH: if ((r_in_done || w_last_in) && !w_ov_nxt) w_state_nxt = ST_DONE;
      ST_DONE:  if (ap_continue) w_state_nxt = ap_start ? ST_RUN : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs; reads stall while an undelivered result is blocked.
  always_comb begin
    ap_idle = 1'b0;
    ap_done = 1'b0;
    w_read  = 1'b0;
    w_write = r_out_valid & layer5_out_V_data_V_full_n;
    case (r_state)
      ST_IDLE:  ap_idle = 1'b1;
      ST_DONE:  ap_done = 1'b1;
      ST_RUN, ST_FLUSH:
        w_read = layer4_out_V_data_V_empty_n & ~r_in_done &
                 ~(r_out_valid & ~layer5_out_V_data_V_full_n);
      default: ;
    endcase
  end

  assign layer4_out_V_data_V_read  = w_read;
  assign layer5_out_V_data_V_write = w_write;
  assign layer5_out_V_data_V_din   = DW'(r_out_reg);
  assign ap_ready                  = r_ready;

  // Frame counters, ready pulse and output holding register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_in_done   <= 1'b0;
      r_out_reg   <= '0;
      r_out_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= w_last_in;
      if (w_frame_start) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_in_done <= 1'b0;
      end else begin
        if (w_read) r_in_cnt <= w_last_in ? '0 : r_in_cnt + IN_W'(1);
        if (w_last_in) r_in_done <= 1'b1;
        if (w_win_last) r_out_cnt <= r_out_cnt + OUT_W'(1);
      end
      if (w_win_last) begin
        r_out_reg   <= w_max;
        r_out_valid <= 1'b1;
      end else if (w_write) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/max_pooling1d_stream.md
# max_pooling1d_stream

Streaming 1-D max-pooling stage placed directly downstream of the Conv1D layer. Consumes one frame of NIN signed 8-bit activations from the Conv1D output FIFO (`layer4_out`), takes the signed maximum over non-overlapping windows of POOL samples, and writes NOUT pooled values to the next layer's FIFO (`layer5_out`). It is controlled by the ap_ block-level handshake, one frame per `ap_start`.

## Interface
- `DW`, 8: sample width, signed two's complement
- `NIN`, 97: samples per input frame (equals Conv1D NOUT)
- `POOL`, 4: window length; stride = POOL, no overlap
- `NOUT`, derived = NIN / POOL (integer division, 24 by default); trailing NIN mod POOL samples are read and discarded
- `ap_clk`  in  1  clock, all logic on rising edge
- `ap_rst_n`  in  1  synchronous, active-low reset
- `ap_start`  in  1  start one frame
- `ap_continue`  in  1  acknowledges `ap_done`
- `ap_done`  out  1  frame complete, held until `ap_continue`
- `ap_ready`  out  1  one-cycle pulse when the last input sample of a frame is read
- `ap_idle`  out  1  high in IDLE
- `layer4_out_V_data_V_dout`  in  DW  input sample
- `layer4_out_V_data_V_empty_n`  in  1  input FIFO has data
- `layer4_out_V_data_V_read`  out  1  pop input; a sample is consumed in every cycle where this is high
- `layer5_out_V_data_V_din`  out  DW  pooled output
- `layer5_out_V_data_V_full_n`  in  1  output FIFO has space
- `layer5_out_V_data_V_write`  out  1  push output; a value is transferred in every cycle where this is high

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN on `ap_start`.
  - RUN → FLUSH when the last sample of window NOUT-1 is read and the remainder is > 0.
  - RUN → DONE when that read leaves no remainder.
  - FLUSH → DONE when input sample NIN-1 is read.
  - DONE → IDLE on `ap_continue`. If `ap_start` is also high in that cycle, go directly to RUN.
- Counters: `in_cnt` 0..NIN-1, `win_pos` 0..POOL-1, `out_cnt` 0..NOUT. All clear on entering RUN.
- Output holding register: `out_reg` and `out_valid`.
  - `write = out_valid & full_n` (combinational).
  - `din = out_reg`.
  - `out_valid` clears on a transfer unless it is reloaded in the same cycle.
- Input read condition: `read = empty_n & (state==RUN | state==FLUSH) & ~(out_valid & ~full_n)`.
  - This stalls input whenever an undelivered result is pending.
  - A drain and a new window completion may occur in the same cycle; the new value wins.
- Window accumulation on each read in RUN:
  - `win_pos==0`: `acc <= dout`.
  - Otherwise: `acc <= $signed(dout) > $signed(acc) ? dout : acc`.
  - `win_pos==POOL-1`: load `out_reg` with the max of `acc` and `dout`, set `out_valid`, increment `out_cnt`.
- Reads in FLUSH only advance `in_cnt`. Data is dropped.
- Ties keep the earlier sample. Values are not saturated; width is unchanged.
- `ap_ready` pulses in the cycle following the read of sample NIN-1.
- `ap_done` asserts on entering DONE, and DONE is entered only once `out_valid` is 0.
  - If the final result is still pending, the FSM waits in RUN/FLUSH (post-input sub-condition) until it is delivered.

## Timing
- Reset (`ap_rst_n` low at a clock edge):
  - state=IDLE; all counters, `acc`, `out_reg` = 0; `out_valid` = 0.
  - Outputs: `read`=0, `write`=0, `din`=0, `ap_done`=0, `ap_ready`=0, `ap_idle`=1.
- Reset mid-frame aborts the frame and discards the pending result. Nothing further is read until the next `ap_start`.
- Latency: the read of a window's last sample at edge t gives `write`=1 in cycle t+1 (if `full_n`).
- Throughput: one input per cycle while `empty_n` and the output is unblocked.
- `empty_n` low: no read, state unchanged.
- `full_n` low with `out_valid`: `din` is held stable and input is stalled.
- `ap_start` is ignored outside IDLE and DONE.

## Structure
- Shared package `hls_stream_pkg`: `sample_t` (logic signed [DW-1:0]), `ap_state_e` enum, and a `smax` function (signed max, tie → first argument).
- One sub-module, `max_window`: accumulator plus `win_pos` counter, flags window complete. The top holds the FSM, counters and output register.
- Elaboration check: `NIN >= POOL` and `POOL >= 2`.

## Test plan
- Frame of samples 0..96 (as signed 8'hxx), `full_n`=1, `empty_n`=1 → 24 writes with values 3, 7, …, 95 in order; sample 96 consumed; `ap_ready` pulse once; then `ap_done`.
- Window {8'h80, 8'hFF, 8'hFE, 8'h81} (all negative) → output 8'hFF. Window {5, 5, 2, 1} → 5.
- `full_n` held low for 10 cycles while a result is pending → `din` stable, `read`=0, no sample lost; all outputs correct after release.
- Random `empty_n` gaps (50% duty) → output sequence identical to the gap-free run.
- `ap_rst_n` low for 1 cycle after 40 samples read → all outputs at reset values. A fresh 97-sample frame after `ap_start` produces the correct 24 values.
- `ap_start` held high in DONE together with `ap_continue` → back-to-back frames, 48 total writes, no dropped or extra reads (194 reads).
